spi_pwm_array: RTL and testbench

Parametrised multi-channel PWM generator whose duty levels are loaded over a write-only SPI-style serial link. It is the next generation of the 7-channel SPI PWM driver: channel count and resolution are configurable, serial frames are fully decoded, and levels are double-buffered so they only change on a period boundary. It sits directly between the tile I/O pins and the PWM outputs.

---
 rtl/spi_pwm_array_if.sv | 22 ++
 rtl/spi_pwm_array.sv | 180 ++++++++++++++++++
 tb/tb_spi_pwm_array.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pwm_array_if.sv
// Serial link bundle for spi_pwm_array: sclk/mosi/cs_n come from the pins and
// miso goes back out. The master side drives the link; the PWM array is the slave.
interface spi_pwm_array_if;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;

    modport master (
        output sclk,
        output mosi,
        output cs_n,
        input  miso
    );

    modport slave (
        input  sclk,
        input  mosi,
        input  cs_n,
        output miso
    );
endinterface

// File: rtl/spi_pwm_array.sv
// Multi-channel PWM generator with duty levels loaded over a write-only serial link.
// Frames are ADDR_W address bits then WIDTH level bits, MSB first. Levels land in a
// shadow bank on cs_n release and are copied to the active bank at the end of each
// PWM period, so outputs only change on a period boundary.
// Optional: define SPI_PWM_ARRAY_MISO_EN to drive miso from the shift register MSB
// (daisy-chain support); otherwise miso is tied low.
module spi_pwm_array #(
    parameter int unsigned NUM_CH = 7,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    spi_pwm_array_if.slave      spi,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic                period_start,
    output logic                frame_err
);

    localparam int unsigned FrameBits = ADDR_W + WIDTH;
    localparam int unsigned CntW      = $clog2(FrameBits + 2);

    localparam logic [CntW-1:0]  FrameLen = CntW'(FrameBits);
    localparam logic [CntW-1:0]  FrameSat = CntW'(FrameBits + 1);
    // 2^WIDTH-2: the period is one clock short of 2^WIDTH so level all-ones is always high.
    localparam logic [WIDTH-1:0] CntMax   = {{(WIDTH - 1){1'b1}}, 1'b0};

    // Synchroniser stages; cs_n idles high so its flops reset high to avoid a fake edge.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;

    logic sclk_rise;
    logic cs_rise;
    logic cs_fall;

    logic [FrameBits-1:0] shift_q, shift_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 frame_err_q;

    logic [ADDR_W-1:0]    frame_addr;
    logic [WIDTH-1:0]     frame_level;
    logic                 frame_ok;
    logic                 frame_bad;

    logic [WIDTH-1:0]     shadow_q [NUM_CH];
    logic [WIDTH-1:0]     active_q [NUM_CH];

    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic                 period_start_q;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_meta_q <= spi.sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= spi.mosi;
            mosi_sync_q <= mosi_meta_q;
            cs_meta_q   <= spi.cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q & cs_prev_q;

    assign frame_addr  = shift_q[FrameBits-1 -: ADDR_W];
    assign frame_level = shift_q[WIDTH-1:0];
    assign frame_ok    = cs_rise && (bit_cnt_q == FrameLen) && (32'(frame_addr) < NUM_CH);
    assign frame_bad   = cs_rise && (bit_cnt_q != FrameLen);

    // Shift on sclk rising edges inside a frame; bit count clears on either cs_n edge.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (cs_rise || cs_fall) begin
            bit_cnt_d = '0;
        end else if (sclk_rise && !cs_sync_q) begin
            shift_d = {shift_q[FrameBits-2:0], mosi_sync_q};
            if (bit_cnt_q != FrameSat) begin
                bit_cnt_d = bit_cnt_q + CntW'(1);
            end
        end
    end

    // Frame receiver state and the error pulse for wrong-length frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= frame_bad;
        end
    end

    // Shadow bank: written by a well-formed frame addressed to an existing channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (frame_ok && (frame_addr == ADDR_W'(i))) begin
                    shadow_q[i] <= frame_level;
                end
            end
        end
    end

    assign cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + WIDTH'(1);

    // Period counter; period_start flags the cycles where the counter has wrapped to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= (cnt_d == '0);
        end
    end

    // Active bank follows the shadow bank once per period, on the last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                active_q[i] <= '0;
            end
        end else if (cnt_q == CntMax) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // PWM compare: level L gives L high cycles per period.
    always_comb begin
        pwm_out = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm_out[i] = (cnt_q < active_q[i]);
        end
    end

    assign period_start = period_start_q;
    assign frame_err    = frame_err_q;

`ifdef SPI_PWM_ARRAY_MISO_EN
    logic miso_q;

    // Registered shift register MSB: replays the incoming stream FrameBits bits later.
    always_ff @(posedge clk) begin
        if (reset) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= shift_q[FrameBits-1];
        end
    end

    assign spi.miso = miso_q;
`else
    assign spi.miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_array.sv
// Directed bench for spi_pwm_array with default parameters (7 ch, 8-bit, 3 addr bits).
module tb_spi_pwm_array;

    localparam int NumCh  = 7;
    localparam int Period = 255;

    logic             clk;
    logic             reset;
    logic [NumCh-1:0] pwm_out;
    logic             period_start;
    logic             frame_err;

    spi_pwm_array_if bus ();

    spi_pwm_array #(
        .NUM_CH (7),
        .WIDTH  (8),
        .ADDR_W (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (bus.slave),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .frame_err    (frame_err)
    );

    int          compared   = 0;
    int          mismatched = 0;
    int          err_cnt    = 0;
    int          err_base;
    int          hi_cnt [NumCh];
    logic [15:0] miso_cap;
    logic [15:0] miso_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame of nbits, MSB first; miso is captured just before each sclk rise.
    task automatic spi_frame(input logic [15:0] data, input int nbits);
        miso_cap = '0;
        bus.cs_n = 1'b0;
        #40;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.mosi = data[i];
            #40;
            miso_cap = {miso_cap[14:0], bus.miso};
            bus.sclk = 1'b1;
            #40;
            bus.sclk = 1'b0;
        end
        #40;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        #80;
    endtask

    // Returns at a negedge where period_start is high (checks the current one first).
    task automatic wait_ps();
        bit ok;
        ok = period_start;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            ok = period_start;
        end
        check("ps_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic clear_hi();
        for (int c = 0; c < NumCh; c++) hi_cnt[c] = 0;
    endtask

    // Accumulate high cycles per channel over one period; ends at the next period_start.
    task automatic count_period();
        for (int k = 0; k < Period; k++) begin
            for (int c = 0; c < NumCh; c++) begin
                if (pwm_out[c] === 1'b1) hi_cnt[c]++;
            end
            @(negedge clk);
        end
        check("period_len", {31'd0, period_start}, 32'd1);
    endtask

    initial begin
        int nz;
        int first_ps;

        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nz;
        int first_ps;

        reset    = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.cs_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_ps", {31'd0, period_start}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_miso", {31'd0, bus.miso}, 32'd0);

        // Outputs quiet for 300 cycles; first wrap 255 cycles after release.
        nz = 0;
        first_ps = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (pwm_out !== '0) nz++;
            if (period_start === 1'b1 && first_ps == 0) first_ps = n;
        end
        check("idle_pwm", 32'(nz), 32'd0);
        check("first_ps", 32'(first_ps), 32'd255);

        // ch0 = 1.
        spi_frame(16'h001, 11);
        wait_ps();
        clear_hi();
        count_period();
        check("ch0_lvl1", 32'(hi_cnt[0]), 32'd1);

        // ch6 = 255 (always high), ch3 = 0 (always low), over 3 periods.
        spi_frame(16'h6FF, 11);
        spi_frame(16'h300, 11);
        wait_ps();
        clear_hi();
        repeat (3) count_period();
        check("ch6_full", 32'(hi_cnt[6]), 32'd765);
        check("ch3_zero", 32'(hi_cnt[3]), 32'd0);
        check("ch0_keep", 32'(hi_cnt[0]), 32'd3);

        // ch2 = 128, then write 64 mid-period: takes effect next period.
        spi_frame(16'h280, 11);
        wait_ps();
        clear_hi();
        count_period();
        check("ch2_128", 32'(hi_cnt[2]), 32'd128);
        clear_hi();
        fork
            count_period();
            begin
                repeat (50) @(negedge clk);
                spi_frame(16'h240, 11);
            end
        join
        check("ch2_mid_cur", 32'(hi_cnt[2]), 32'd128);
        clear_hi();
        count_period();
        check("ch2_next_64", 32'(hi_cnt[2]), 32'd64);

        // 10-bit frame errors; 11-bit frame to addr 7 silently dropped.
        err_base = err_cnt;
        spi_frame(16'h3FF, 10);
        check("short_err", 32'(err_cnt - err_base), 32'd1);
        spi_frame(16'h710, 11);
        check("addr7_noerr", 32'(err_cnt - err_base), 32'd1);
        wait_ps();
        clear_hi();
        count_period();
        check("keep_ch0", 32'(hi_cnt[0]), 32'd1);
        check("keep_ch2", 32'(hi_cnt[2]), 32'd64);
        check("keep_ch3", 32'(hi_cnt[3]), 32'd0);
        check("keep_ch6", 32'(hi_cnt[6]), 32'd255);

        // Reset after 5 bits of a frame; partial frame lost.
        bus.cs_n = 1'b0;
        #40;
        for (int i = 10; i >= 6; i--) begin
            bus.mosi = (i % 2 == 0);
            #40;
            bus.sclk = 1'b1;
            #40;
            bus.sclk = 1'b0;
        end
        @(negedge clk);
        reset    = 1'b1;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        check("midrst_pwm", 32'(pwm_out), 32'd0);

        // Full frame ch1 = 200, then a dropped frame to addr 7 to observe miso.
        spi_frame(16'h1C8, 11);
        spi_frame(16'h755, 11);
`ifdef SPI_PWM_ARRAY_MISO_EN
        miso_exp = 16'h1C8;
`else
        miso_exp = 16'h000;
`endif
        check("miso_replay", 32'(miso_cap), 32'(miso_exp));
        wait_ps();
        clear_hi();
        count_period();
        check("ch1_200", 32'(hi_cnt[1]), 32'd200);
        check("ch0_cleared", 32'(hi_cnt[0]), 32'd0);
        check("ch6_cleared", 32'(hi_cnt[6]), 32'd0);
        check("rst_noerr", 32'(err_cnt - err_base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
